// File: rtl/imem_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package imem_prefetch_pkg;

  localparam int          ILEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int          DISC_W  = 16;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [31:0]     pc;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// In-order FIFO of fetch entries with synchronous flush; flush wins over push and pop.
module prefetch_fifo
  import imem_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  fetch_entry_t          push_data_i,
  input  logic                  pop_i,
  output fetch_entry_t          head_o,
  output logic [ptr_w(DEPTH):0] count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot, so a push into a full FIFO is still legal that cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/imem_prefetch.sv
// Sequential instruction prefetcher with credit-limited ROM requests and redirect flush.
// Optional statistics counters are enabled by defining IMEM_PREFETCH_STATS_EN.
module imem_prefetch
  import imem_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
`ifdef IMEM_PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_flushes,
  output logic [31:0] stat_discards
`endif
);

  localparam int CW = ptr_w(DEPTH) + 1;

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [DISC_W-1:0] discard_q, discard_d;
  logic [CW-1:0]     q_count, tag_count;
  logic [CW:0]       in_use;
  logic              q_empty, q_full, tag_empty, tag_full;
  logic              accept, drop, pop;
  fetch_entry_t      q_head, q_wdata, tag_head, tag_wdata;
  logic              unused_tag_bits;

  // Valid/ready: the head transfers on a cycle where out_valid && out_ready are both
  // high and no flush is present; a flush cycle voids the handshake.
  // The tag FIFO occupancy is the number of live (non-discarded) outstanding requests.
  assign in_use    = {1'b0, q_count} + {1'b0, tag_count};
  assign mem_req   = reset_n && !flush && (in_use < (CW+1)'(DEPTH));
  assign mem_addr  = fetch_pc_q;
  assign accept    = mem_rvalid && !flush && (discard_q == '0);
  assign drop      = mem_rvalid && (flush || (discard_q != '0));
  assign out_valid = !q_empty;
  assign pop       = out_valid && out_ready && !flush;
  assign out_instr = q_head.instr;
  assign out_pc    = q_head.pc;
  assign q_wdata   = '{instr: mem_rdata, pc: tag_head.pc};
  assign tag_wdata = '{instr: '0, pc: fetch_pc_q};
  assign unused_tag_bits = ^tag_head.instr;

  prefetch_fifo #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush),
    .push_i      (accept),
    .push_data_i (q_wdata),
    .pop_i       (pop),
    .head_o      (q_head),
    .count_o     (q_count),
    .empty_o     (q_empty),
    .full_o      (q_full)
  );

  prefetch_fifo #(.DEPTH(DEPTH)) u_tags (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush),
    .push_i      (mem_req),
    .push_data_i (tag_wdata),
    .pop_i       (accept),
    .head_o      (tag_head),
    .count_o     (tag_count),
    .empty_o     (tag_empty),
    .full_o      (tag_full)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (flush) begin
      // Everything still in flight, minus this cycle's response, must be dropped.
      fetch_pc_d = flush_pc;
      discard_d  = discard_q + DISC_W'(tag_count) - DISC_W'(mem_rvalid);
    end else begin
      if (mem_req) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (mem_rvalid && (discard_q != '0)) discard_d = discard_q - DISC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

`ifdef IMEM_PREFETCH_STATS_EN
  logic [31:0] stat_flushes_q, stat_discards_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_flushes_q  <= '0;
      stat_discards_q <= '0;
    end else begin
      if (flush && (stat_flushes_q != '1))  stat_flushes_q  <= stat_flushes_q + 32'd1;
      if (drop && (stat_discards_q != '1))  stat_discards_q <= stat_discards_q + 32'd1;
    end
  end

  assign stat_flushes  = stat_flushes_q;
  assign stat_discards = stat_discards_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_rvalid && q_full));
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset_n)
    !(accept && tag_empty));
  a_tag_room: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_req && tag_full));

endmodule

// File: tb/tb_imem_prefetch.sv
// Directed vector bench for imem_prefetch with a variable-latency in-order ROM model.
module tb_imem_prefetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
`ifdef IMEM_PREFETCH_STATS_EN
  logic [31:0] stat_flushes;
  logic [31:0] stat_discards;
`endif

  imem_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
`ifdef IMEM_PREFETCH_STATS_EN
    ,
    .stat_flushes  (stat_flushes),
    .stat_discards (stat_discards)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ROM model: fixed latency shift pipe, data derived from the address
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  int          rom_lat = 1;
  logic        pipe_v [8] = '{default: 1'b0};
  logic [31:0] pipe_a [8] = '{default: 32'h0};
  logic        cap_req = 1'b0;
  logic [31:0] cap_addr = '0;

  always @(negedge clk) begin
    cap_req  = mem_req;
    cap_addr = mem_addr;
  end

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) pipe_v[i] = 1'b0;
    end else begin
      for (int i = 7; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_a[i] = pipe_a[i-1];
      end
      pipe_v[0] = cap_req;
      pipe_a[0] = cap_addr;
    end
    mem_rvalid = pipe_v[rom_lat-1];
    mem_rdata  = pipe_v[rom_lat-1] ? rom_word(pipe_a[rom_lat-1]) : 32'h0;
  end

  // scoreboard
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // driver tasks
  task automatic do_reset(input int lat, input logic rdy);
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = rdy;
    rom_lat   = lat;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    int          lat;
    logic        rdy;
    logic        fl;
    logic [31:0] fpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input int lat, input logic rdy, input logic fl,
                     input logic [31:0] fpc, input logic ev, input logic [31:0] epc,
                     input logic ereq, input logic [31:0] eaddr);
    vec_t v;
    v = '{rst, lat, rdy, fl, fpc, ev, epc, ereq, eaddr};
    tv.push_back(v);
  endtask

  initial begin
    // S1: latency 1, always ready, streaming from reset
    add(1, 1, 1, 0, 0, 0, 32'h00, 1, 32'h00);
    add(0, 1, 1, 0, 0, 0, 32'h00, 1, 32'h04);
    add(0, 1, 1, 0, 0, 1, 32'h00, 1, 32'h08);
    add(0, 1, 1, 0, 0, 1, 32'h04, 1, 32'h0C);
    add(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h10);
    add(0, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h14);
    // S2: core stalls 10 cycles, credit stops at DEPTH requests, then drains
    add(1, 1, 0, 0, 0, 0, 32'h00, 1, 32'h00);
    add(0, 1, 0, 0, 0, 0, 32'h00, 1, 32'h04);
    add(0, 1, 0, 0, 0, 1, 32'h00, 1, 32'h08);
    add(0, 1, 0, 0, 0, 1, 32'h00, 1, 32'h0C);
    for (int i = 4; i < 10; i++) add(0, 1, 0, 0, 0, 1, 32'h00, 0, 32'h10);
    add(0, 1, 1, 0, 0, 1, 32'h00, 0, 32'h10);
    add(0, 1, 1, 0, 0, 1, 32'h04, 1, 32'h10);
    add(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h14);
    add(0, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h18);
    // S3: latency 3, flush to 0x100 with three requests in flight
    add(1, 3, 1, 0, 0,         0, 32'h000, 1, 32'h000);
    add(0, 3, 1, 0, 0,         0, 32'h000, 1, 32'h004);
    add(0, 3, 1, 0, 0,         0, 32'h000, 1, 32'h008);
    add(0, 3, 1, 1, 32'h100,   0, 32'h000, 0, 32'h00C);
    add(0, 3, 1, 0, 0,         0, 32'h000, 1, 32'h100);
    add(0, 3, 1, 0, 0,         0, 32'h000, 1, 32'h104);
    add(0, 3, 1, 0, 0,         0, 32'h000, 1, 32'h108);
    add(0, 3, 1, 0, 0,         0, 32'h000, 1, 32'h10C);
    add(0, 3, 1, 0, 0,         1, 32'h100, 0, 32'h110);
    add(0, 3, 1, 0, 0,         1, 32'h104, 1, 32'h110);
    // S4: flush coincides with a response and a head handshake
    add(1, 1, 1, 0, 0,       0, 32'h00, 1, 32'h00);
    add(0, 1, 1, 0, 0,       0, 32'h00, 1, 32'h04);
    add(0, 1, 1, 0, 0,       1, 32'h00, 1, 32'h08);
    add(0, 1, 1, 0, 0,       1, 32'h04, 1, 32'h0C);
    add(0, 1, 1, 1, 32'h40,  1, 32'h08, 0, 32'h10);
    add(0, 1, 1, 0, 0,       0, 32'h00, 1, 32'h40);
    add(0, 1, 1, 0, 0,       0, 32'h00, 1, 32'h44);
    add(0, 1, 1, 0, 0,       1, 32'h40, 1, 32'h48);
    add(0, 1, 1, 0, 0,       1, 32'h44, 1, 32'h4C);
    // S5: back-to-back flushes at latency 3; only the second target survives
    add(1, 3, 1, 0, 0,        0, 32'h000, 1, 32'h000);
    add(0, 3, 1, 0, 0,        0, 32'h000, 1, 32'h004);
    add(0, 3, 1, 0, 0,        0, 32'h000, 1, 32'h008);
    add(0, 3, 1, 1, 32'h200,  0, 32'h000, 0, 32'h00C);
    add(0, 3, 1, 1, 32'h300,  0, 32'h000, 0, 32'h200);
    add(0, 3, 1, 0, 0,        0, 32'h000, 1, 32'h300);
    add(0, 3, 1, 0, 0,        0, 32'h000, 1, 32'h304);
    add(0, 3, 1, 0, 0,        0, 32'h000, 1, 32'h308);
    add(0, 3, 1, 0, 0,        0, 32'h000, 1, 32'h30C);
    add(0, 3, 1, 0, 0,        1, 32'h300, 0, 32'h310);
    add(0, 3, 1, 0, 0,        1, 32'h304, 1, 32'h310);
    // S6: fetch address wraps past 0xFFFF_FFFC
    add(1, 1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0,         0, 32'h0);
    add(0, 1, 1, 0, 0,             0, 32'h0,         1, 32'hFFFF_FFF8);
    add(0, 1, 1, 0, 0,             0, 32'h0,         1, 32'hFFFF_FFFC);
    add(0, 1, 1, 0, 0,             1, 32'hFFFF_FFF8, 1, 32'h0);
    add(0, 1, 1, 0, 0,             1, 32'hFFFF_FFFC, 1, 32'h4);
    add(0, 1, 1, 0, 0,             1, 32'h0,         1, 32'h8);

    // reset state while reset is held
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset mem_req",   32'(mem_req),   32'h0);
    check("reset mem_addr",  mem_addr,       32'h0);
    check("reset out_pc",    out_pc,         32'h0);
    check("reset out_instr", out_instr,      32'h0);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset(tv[i].lat, tv[i].rdy);
      out_ready = tv[i].rdy;
      flush     = tv[i].fl;
      flush_pc  = tv[i].fpc;
      @(negedge clk);
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tv[i].exp_valid));
      check($sformatf("v%0d mem_req", i),   32'(mem_req),   32'(tv[i].exp_req));
      check($sformatf("v%0d mem_addr", i),  mem_addr,       tv[i].exp_addr);
      if (tv[i].exp_valid) begin
        check($sformatf("v%0d out_pc", i),    out_pc,    tv[i].exp_pc);
        check($sformatf("v%0d out_instr", i), out_instr, rom_word(tv[i].exp_pc));
      end
      step();
    end
    flush = 1'b0;

    // reset asserted mid-stream takes effect immediately, then restarts cleanly
    do_reset(1, 1);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'h0);
    check("midreset mem_req",   32'(mem_req),   32'h0);
    check("midreset mem_addr",  mem_addr,       32'h0);
    check("midreset out_pc",    out_pc,         32'h0);
    check("midreset out_instr", out_instr,      32'h0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    check("restart c1 out_valid", 32'(out_valid), 32'h0);
    step();
    @(negedge clk);
    check("restart c2 out_valid", 32'(out_valid), 32'h1);
    check("restart c2 out_pc",    out_pc,         32'h0);
    check("restart c2 out_instr", out_instr,      rom_word(32'h0));

`ifdef IMEM_PREFETCH_STATS_EN
    // statistics: one flush dropping three stale words at latency 3
    do_reset(3, 1);
    @(negedge clk);
    check("stats reset flushes",  stat_flushes,  32'd0);
    check("stats reset discards", stat_discards, 32'd0);
    step();
    step();
    step();
    flush    = 1'b1;
    flush_pc = 32'h100;
    step();
    flush = 1'b0;
    repeat (8) step();
    @(negedge clk);
    check("stats flushes",  stat_flushes,  32'd1);
    check("stats discards", stat_discards, 32'd3);
    check("stats out_valid", 32'(out_valid), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
